// File: rtl/mux_arbiter_2ch.sv
// Round-robin owner of a shared 2:1 WIDTH-bit mux: grants one requester per burst,
// drives the mux select and exposes the selected data over a valid/ready handshake.
module mux_arbiter_2ch #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_s;
    logic            last_r;
    logic            last_s;
    logic            sel_r;
    logic            sel_s;
    logic            gnt0_r;
    logic            gnt1_r;
    logic            valid_s;
    logic            accept_s;
    logic            limit_s;
    logic [CW-1:0]   cnt_inc_s;

    // Handshake view of the current grant and burst-limit detection
    always_comb begin
        valid_s   = (gnt0_r & req0) | (gnt1_r & req1);
        accept_s  = valid_s & out_ready;
        cnt_inc_s = cnt_r + CNT_ONE;
        if (accept_s && (cnt_inc_s == CNT_LIMIT)) begin
            limit_s = 1'b1;
        end else begin
            limit_s = 1'b0;
        end
    end

    // Next-state, burst counter, round-robin pointer and select
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        last_s  = last_r;
        sel_s   = sel_r;
        case (state_r)
            IDLE: begin
                // On a tie the requester that was not served last wins.
                if (req0 && req1) begin
                    if (last_r) begin
                        state_s = GRANT0;
                        sel_s   = 1'b0;
                    end else begin
                        state_s = GRANT1;
                        sel_s   = 1'b1;
                    end
                    cnt_s = CNT_ZERO;
                end else if (req0) begin
                    state_s = GRANT0;
                    sel_s   = 1'b0;
                    cnt_s   = CNT_ZERO;
                end else if (req1) begin
                    state_s = GRANT1;
                    sel_s   = 1'b1;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT0: begin
                if (!req0 || limit_s) begin
                    last_s = 1'b0;
                    if (req1) begin
                        state_s = GRANT1;
                        sel_s   = 1'b1;
                        cnt_s   = CNT_ZERO;
                    end else if (req0) begin
                        state_s = GRANT0;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (accept_s) begin
                    cnt_s = cnt_inc_s;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            GRANT1: begin
                if (!req1 || limit_s) begin
                    last_s = 1'b1;
                    if (req0) begin
                        state_s = GRANT0;
                        sel_s   = 1'b0;
                        cnt_s   = CNT_ZERO;
                    end else if (req1) begin
                        state_s = GRANT1;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (accept_s) begin
                    cnt_s = cnt_inc_s;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
                last_s  = 1'b1;
                sel_s   = 1'b0;
            end
        endcase
    end

    // State, counter, pointer and registered grant/select outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            last_r  <= 1'b1;
            sel_r   <= 1'b0;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            last_r  <= last_s;
            sel_r   <= sel_s;
            gnt0_r  <= (state_s == GRANT0);
            gnt1_r  <= (state_s == GRANT1);
        end
    end

    assign gnt0      = gnt0_r;
    assign gnt1      = gnt1_r;
    assign sel       = sel_r;
    assign out_valid = valid_s;
    assign out_data  = sel_r ? data1 : data0;

endmodule

// Invariants of the arbiter outputs, kept apart from the design logic.
module mux_arbiter_2ch_chk (
    input logic clk,
    input logic rst,
    input logic gnt0,
    input logic gnt1,
    input logic sel,
    input logic out_valid
);

    a_onehot_gnt: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
    a_sel_gnt0:   assert property (@(posedge clk) disable iff (rst) gnt0 |-> !sel);
    a_sel_gnt1:   assert property (@(posedge clk) disable iff (rst) gnt1 |-> sel);
    a_valid_gnt:  assert property (@(posedge clk) disable iff (rst) out_valid |-> (gnt0 || gnt1));

endmodule
